// File: rtl/pt_host_pkg.sv
// Shared definitions for the page-table host: cache command codes, table layout
// and FSM state encoding.
package pt_host_pkg;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_LD  = 2'b11
    } cmd_e;

    // Table layout: bytes 0-15 page table, 16-19 PTE area, byte 20 carries the PID.
    localparam int TABLE_SIZE = 21;
    localparam int PTE_BASE   = 16;
    localparam int PID_IDX    = 20;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_WAIT  = 3'd1;
    localparam logic [2:0] S_WR_PULSE = 3'd2;
    localparam logic [2:0] S_WR_GAP   = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_LD_WAIT  = 3'd5;
    localparam logic [2:0] S_RELEASE  = 3'd6;

    function automatic logic is_wait_state(input logic [2:0] s);
        return (s == S_WR_WAIT) || (s == S_RD_WAIT) || (s == S_LD_WAIT);
    endfunction

endpackage

// File: rtl/pt_host_timeout.sv
// Watchdog for the cache port: counts enabled cycles up to a loaded limit and
// flags expiry; clear restarts it from zero.
module pt_host_timeout (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] count_q, count_d;

    // Saturate at the limit so a stalled wait keeps reporting expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != limit_i)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == limit_i);

endmodule

// File: rtl/pt_host.sv
// Host-side sequencer driving the page-table cache port: table writes, address
// translations and table dumps, with a watchdog abort on every wait.
module pt_host
    import pt_host_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int NOP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_op_i,
    input  logic [3:0] req_pid_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_valid_o,
    output logic       rsp_fault_o,
    output logic       rsp_last_o,
    output logic [1:0] cmd_o,
    output logic       datavalid_o,
    output logic [7:0] datain_o,
    output logic [3:0] PID_o,
    input  logic [7:0] dataout_i,
    input  logic       outvalid_i,
    input  logic       pagefault_i,
    input  logic       wd_i
);

    logic [2:0] state_q, state_d;
    cmd_e       cmd_q, cmd_d;
    logic [3:0] pid_q, pid_d;
    logic [7:0] datain_q, datain_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] nop_q, nop_d;
    logic       outvalid_prev_q;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_fault_q, rsp_fault_d;
    logic       rsp_last_q, rsp_last_d;
    logic       go_release, expired, ld_edge, last_byte;

    assign ld_edge   = outvalid_i && !outvalid_prev_q;
    assign last_byte = (cnt_q == 5'(PID_IDX));

    pt_host_timeout u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!is_wait_state(state_q) || (state_q == S_LD_WAIT && ld_edge)),
        .en_i      (is_wait_state(state_q)),
        .limit_i   (8'(TIMEOUT)),
        .expired_o (expired)
    );

    // A real event in a wait state always wins over a coincident watchdog expiry.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pid_d       = pid_q;
        datain_d    = datain_q;
        cnt_d       = cnt_q;
        nop_d       = nop_q;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_last_d  = 1'b0;
        go_release  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_op_i != CMD_NOP) begin
                    cmd_d = cmd_e'(req_op_i);
                    pid_d = req_pid_i;
                    cnt_d = '0;
                    case (req_op_i)
                        CMD_RD: begin
                            datain_d = req_addr_i;
                            state_d  = S_RD_WAIT;
                        end
                        CMD_WR:  state_d = S_WR_WAIT;
                        default: state_d = S_LD_WAIT;
                    endcase
                end
            end
            S_WR_WAIT: begin
                if (wd_i && last_byte) begin
                    datain_d = {4'h0, pid_q};
                    state_d  = S_WR_PULSE;
                end else if (wd_i && wr_valid_i) begin
                    datain_d = wr_data_i;
                    state_d  = S_WR_PULSE;
                end else if (expired) begin
                    go_release = 1'b1;
                end
            end
            S_WR_PULSE: state_d = S_WR_GAP;
            S_WR_GAP: begin
                if (last_byte) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    go_release  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (outvalid_i || pagefault_i) begin
                    rsp_data_d  = dataout_i;
                    rsp_fault_d = pagefault_i;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    go_release  = 1'b1;
                end else if (expired) begin
                    go_release = 1'b1;
                end
            end
            S_LD_WAIT: begin
                if (ld_edge) begin
                    rsp_data_d  = dataout_i;
                    rsp_valid_d = 1'b1;
                    if (cnt_q == 5'(TABLE_SIZE - 1)) begin
                        rsp_last_d = 1'b1;
                        go_release = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else if (expired) begin
                    go_release = 1'b1;
                end
            end
            S_RELEASE: begin
                if (nop_q == 8'(NOP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    nop_d = nop_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go_release) begin
            if (is_wait_state(state_q) && !rsp_valid_d) begin
                rsp_valid_d = 1'b1;
                rsp_fault_d = 1'b1;
                rsp_last_d  = 1'b1;
            end
            state_d = S_RELEASE;
            cmd_d   = CMD_NOP;
            nop_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cmd_q           <= CMD_NOP;
            pid_q           <= '0;
            datain_q        <= '0;
            cnt_q           <= '0;
            nop_q           <= '0;
            outvalid_prev_q <= 1'b0;
            rsp_data_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_fault_q     <= 1'b0;
            rsp_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            pid_q           <= pid_d;
            datain_q        <= datain_d;
            cnt_q           <= cnt_d;
            nop_q           <= nop_d;
            outvalid_prev_q <= outvalid_i;
            rsp_data_q      <= rsp_data_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_fault_q     <= rsp_fault_d;
            rsp_last_q      <= rsp_last_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR_WAIT) && wd_i && !last_byte;
    assign datavalid_o = (state_q == S_WR_PULSE);
    assign cmd_o       = cmd_q;
    assign PID_o       = pid_q;
    assign datain_o    = datain_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_fault_o = rsp_fault_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_pt_host.sv
// Scoreboard bench for pt_host: directed requests push expected responses, a
// negedge monitor pops and compares them and watches the cache-port pulses.
module tb_pt_host;
    import pt_host_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       reqValid, reqReady;
    logic [1:0] reqOp;
    logic [3:0] reqPid;
    logic [7:0] reqAddr;
    logic [7:0] wrData;
    logic       wrValid, wrReady;
    logic [7:0] rspData;
    logic       rspValid, rspFault, rspLast;
    logic [1:0] cmd;
    logic       datavalid;
    logic [7:0] datain;
    logic [3:0] pidOut;
    logic [7:0] dataout;
    logic       outvalid, pagefault, wd;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fault;
        logic       last;
    } rspExp_t;

    rspExp_t    sbQ[$];
    logic [7:0] dvData[$];
    logic [1:0] dvCmd[$];
    logic [3:0] dvPid[$];
    int         relRun  = 0;
    int         lastRel = 0;
    logic       prevDv  = 1'b0;

    always #5 clk = ~clk;

    pt_host #(.TIMEOUT(255), .NOP_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_op_i    (reqOp),
        .req_pid_i   (reqPid),
        .req_addr_i  (reqAddr),
        .wr_data_i   (wrData),
        .wr_valid_i  (wrValid),
        .wr_ready_o  (wrReady),
        .rsp_data_o  (rspData),
        .rsp_valid_o (rspValid),
        .rsp_fault_o (rspFault),
        .rsp_last_o  (rspLast),
        .cmd_o       (cmd),
        .datavalid_o (datavalid),
        .datain_o    (datain),
        .PID_o       (pidOut),
        .dataout_i   (dataout),
        .outvalid_i  (outvalid),
        .pagefault_i (pagefault),
        .wd_i        (wd)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard pops, datavalid logging, RELEASE length measurement.
    initial begin
        rspExp_t exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevDv = 1'b0;
                relRun = 0;
            end else begin
                if (rspValid) begin
                    checkOutput("rsp_with_req_ready", 32'(reqReady), 32'd0);
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(rspValid), 32'd0);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("rsp_data", 32'(rspData), 32'(exp.data));
                        checkOutput("rsp_fault", 32'(rspFault), 32'(exp.fault));
                        checkOutput("rsp_last", 32'(rspLast), 32'(exp.last));
                    end
                end
                if (datavalid) begin
                    checkOutput("datavalid_back_to_back", 32'(prevDv), 32'd0);
                    dvData.push_back(datain);
                    dvCmd.push_back(cmd);
                    dvPid.push_back(pidOut);
                end
                prevDv = datavalid;
                if (cmd == 2'b00 && !reqReady) begin
                    relRun++;
                end else if (relRun != 0) begin
                    lastRel = relRun;
                    relRun  = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic clearLogs();
        dvData.delete();
        dvCmd.delete();
        dvPid.delete();
        lastRel = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] pid, input logic [7:0] addr);
        @(posedge clk); #1;
        reqValid = 1'b1;
        reqOp    = op;
        reqPid   = pid;
        reqAddr  = addr;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (reqReady) break;
        end
        checkOutput({name, "_idle"}, 32'(reqReady), 32'd1);
        #1;
    endtask

    // Feeds bytes 0..19 on the write stream until IDLE returns or pulse stopAt is seen.
    task automatic feedWrite(input int stopAt, output bit stopped, output int cycles);
        int  idx  = 0;
        int  seen = 0;
        bit  hs;
        stopped = 1'b0;
        cycles  = -1;
        wrValid = 1'b1;
        wrData  = 8'h00;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (reqReady) begin
                cycles = c;
                break;
            end
            if (datavalid) seen++;
            if (stopAt != 0 && seen == stopAt) begin
                stopped = 1'b1;
                break;
            end
            hs = wrValid && wrReady;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx < 20) wrData = 8'(idx);
                else          wrValid = 1'b0;
            end
        end
        wrValid = 1'b0;
    endtask

    task automatic runRead(input logic [3:0] pid, input logic [7:0] addr,
                           input logic [7:0] data, input logic fault, input string name);
        clearLogs();
        sbQ.push_back('{data, fault, 1'b1});
        applyStimulus(CMD_RD, pid, addr);
        @(negedge clk);
        checkOutput({name, "_cmd"}, 32'(cmd), 32'(CMD_RD));
        checkOutput({name, "_datain"}, 32'(datain), 32'(addr));
        checkOutput({name, "_pid"}, 32'(pidOut), 32'(pid));
        @(posedge clk); #1;
        dataout = data;
        if (fault) pagefault = 1'b1;
        else       outvalid  = 1'b1;
        @(posedge clk); #1;
        outvalid  = 1'b0;
        pagefault = 1'b0;
        waitIdle(name);
        checkOutput({name, "_release_len"}, 32'(lastRel), 32'd2);
        checkOutput({name, "_drained"}, 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        bit stopped;
        int cycles;
        rst = 1'b1;
        reqValid = 1'b0; reqOp = 2'b00; reqPid = 4'h0; reqAddr = 8'h00;
        wrData = 8'h00; wrValid = 1'b0;
        dataout = 8'h00; outvalid = 1'b0; pagefault = 1'b0; wd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_cmd", 32'(cmd), 32'd0);
        checkOutput("reset_datavalid", 32'(datavalid), 32'd0);
        checkOutput("reset_datain", 32'(datain), 32'd0);
        checkOutput("reset_pid", 32'(pidOut), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset_wr_ready", 32'(wrReady), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(reqReady), 32'd1);

        $display("[TB] op 00 is dropped");
        applyStimulus(2'b00, 4'hA, 8'h11);
        @(negedge clk);
        checkOutput("nop_req_ready", 32'(reqReady), 32'd1);
        checkOutput("nop_cmd", 32'(cmd), 32'd0);

        $display("[TB] table write pid=3");
        clearLogs();
        wd = 1'b1;
        sbQ.push_back('{8'h00, 1'b0, 1'b1});
        applyStimulus(CMD_WR, 4'h3, 8'h00);
        feedWrite(0, stopped, cycles);
        checkOutput("wr_idle", 32'(reqReady), 32'd1);
        #1;
        checkOutput("wr_pulse_count", 32'(dvData.size()), 32'd21);
        for (int i = 0; i < 21 && i < dvData.size(); i++) begin
            checkOutput($sformatf("wr_byte%0d", i), 32'(dvData[i]), (i < 20) ? 32'(i) : 32'h03);
            checkOutput($sformatf("wr_cmd%0d", i), 32'(dvCmd[i]), 32'(CMD_WR));
        end
        if (dvPid.size() > 0) checkOutput("wr_pid", 32'(dvPid[0]), 32'h3);
        checkOutput("wr_release_len", 32'(lastRel), 32'd2);
        checkOutput("wr_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] translate pid=2 addr=0x90");
        wd = 1'b0;
        runRead(4'h2, 8'h90, 8'h5A, 1'b0, "rd_hit");

        $display("[TB] translate pid=5 with page fault");
        runRead(4'h5, 8'h44, 8'h33, 1'b1, "rd_fault");

        $display("[TB] dump table");
        clearLogs();
        for (int i = 0; i < 21; i++) sbQ.push_back('{8'(8'h40 + i), 1'b0, (i == 20)});
        applyStimulus(CMD_LD, 4'h1, 8'h00);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            outvalid = 1'b1;
            dataout  = 8'(8'h40 + i);
            if (i == 5) repeat (2) @(posedge clk);
            if (i == 5) #1;
            @(posedge clk); #1;
            outvalid = 1'b0;
        end
        waitIdle("ld");
        checkOutput("ld_no_pulses", 32'(dvData.size()), 32'd0);
        checkOutput("ld_release_len", 32'(lastRel), 32'd2);
        checkOutput("ld_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] write with wd held low times out");
        clearLogs();
        wd = 1'b0;
        sbQ.push_back('{8'h00, 1'b1, 1'b1});
        applyStimulus(CMD_WR, 4'h7, 8'h00);
        feedWrite(0, stopped, cycles);
        checkOutput("to_idle", 32'(reqReady), 32'd1);
        #1;
        checkOutput("to_latency", 32'(cycles), 32'd258);
        checkOutput("to_no_pulses", 32'(dvData.size()), 32'd0);
        checkOutput("to_release_len", 32'(lastRel), 32'd2);
        checkOutput("to_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] reset during 10th write pulse");
        clearLogs();
        wd = 1'b1;
        applyStimulus(CMD_WR, 4'h3, 8'h00);
        feedWrite(10, stopped, cycles);
        checkOutput("rst_at_pulse10", 32'(stopped), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_datavalid", 32'(datavalid), 32'd0);
        checkOutput("rst_cmd", 32'(cmd), 32'd0);
        checkOutput("rst_datain", 32'(datain), 32'd0);
        checkOutput("rst_pid", 32'(pidOut), 32'd0);
        checkOutput("rst_wr_ready", 32'(wrReady), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        @(negedge clk);
        checkOutput("rst_next_datavalid", 32'(datavalid), 32'd0);
        checkOutput("rst_next_cmd", 32'(cmd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wd  = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
        runRead(4'h1, 8'h12, 8'hC3, 1'b0, "rd_after_rst");

        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
